// File: rtl/ps2_note_sched.sv
`timescale 1ns / 1ps
// ps2_note_sched
// Sequencing controller between the PS/2 scan-code receiver and the tone datapath.
// It parses make/break/extended byte sequences and keeps a last-pressed-wins stack of held keys.
// The top of the stack drives the tone nibbles, and the stack depth drives the audio gate.
// A valid flag is raised for every change of tone or gate. Only the latest change is kept;
// earlier changes are not queued.
//
// Optional build macro: NOTE_SCHED_RELEASE_EN
//   When this macro is defined, audio_en stays high for RELEASE_CYCLES cycles after the
//   last key is released.
//
// Ports:
//   CLOCK_50   in   clock, rising edge
//   resetn     in   asynchronous active-low reset
//   ps2_byte   in   [7:0] received scan-code byte
//   ps2_valid  in   one-cycle strobe qualifying ps2_byte
//   upd_ready  in   tone datapath accepts the pending update
//   upd_valid  out  tone/gate update pending
//   tone_hi    out  [3:0] upper nibble of sounding scan code
//   tone_lo    out  [3:0] lower nibble of sounding scan code
//   audio_en   out  audio gate
//   held_cnt   out  [3:0] number of held keys on the stack
//   overflow   out  one-cycle pulse when the oldest held key is dropped
module ps2_note_sched #(
   parameter int unsigned DEPTH          = 4,
   parameter int unsigned RELEASE_CYCLES = 2500000
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic [7:0] ps2_byte,
   input  logic       ps2_valid,
   input  logic       upd_ready,
   output logic       upd_valid,
   output logic [3:0] tone_hi,
   output logic [3:0] tone_lo,
   output logic       audio_en,
   output logic [3:0] held_cnt,
   output logic       overflow
);

   typedef enum logic [1:0] {StIdle, StBrk, StExt, StExtBrk} state_t;

   state_t     st_q, st_d;
   logic [7:0] stk_q [DEPTH];
   logic [7:0] stk_d [DEPTH];
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] tone_q, tone_d;
   logic       aud_q, aud_d;
   logic       vld_q, vld_d;
   logic       ovf_q, ovf_d;
   logic       is_make, is_break;
   logic       hit;
   logic [3:0] hit_idx;
   logic [7:0] top_d;
   logic       chg;

   // Parser: classify the incoming byte as a make, a break, or a byte to ignore.
   always_comb begin
      st_d     = st_q;
      is_make  = 1'b0;
      is_break = 1'b0;
      if (ps2_valid) begin
         unique case (st_q)
            StIdle: begin
               if (ps2_byte == 8'hF0) begin
                  st_d = StBrk;
               end else if (ps2_byte == 8'hE0) begin
                  st_d = StExt;
               end else if (!(ps2_byte inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF})) begin
                  is_make = 1'b1;
               end
            end
            StBrk: begin
               is_break = 1'b1;
               st_d     = StIdle;
            end
            // Extended keys never sound: their make and break sequences are swallowed.
            StExt:    st_d = (ps2_byte == 8'hF0) ? StExtBrk : StIdle;
            StExtBrk: st_d = StIdle;
            default:  st_d = StIdle;
         endcase
      end
   end

   // Find the lowest valid slot that holds the incoming byte.
   // A key is stored at most once, so there is never more than one match.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!hit && (4'(i) < cnt_q) && (stk_q[i] == ps2_byte)) begin
            hit     = 1'b1;
            hit_idx = 4'(i);
         end
      end
   end

   // Stack edit. Slot 0 is the oldest key and slot cnt-1 is the top.
   // Slots at or above cnt hold stale data that is never read.
   always_comb begin
      stk_d = stk_q;
      cnt_d = cnt_q;
      ovf_d = 1'b0;
      if (is_make) begin
         if (!hit) begin
            if (cnt_q == 4'(DEPTH)) begin
               for (int i = 0; i < DEPTH - 1; i++) begin
                  stk_d[i] = stk_q[i + 1];
               end
               stk_d[DEPTH-1] = ps2_byte;
               ovf_d          = 1'b1;
            end else begin
               for (int i = 0; i < DEPTH; i++) begin
                  if (4'(i) == cnt_q) begin
                     stk_d[i] = ps2_byte;
                  end
               end
               cnt_d = cnt_q + 4'd1;
            end
         end else if (hit_idx != cnt_q - 4'd1) begin
            // The key is held but is not on top. Close the gap it leaves, then re-place it on top.
            for (int i = 0; i < DEPTH - 1; i++) begin
               if ((4'(i) >= hit_idx) && (4'(i) + 4'd1 < cnt_q)) begin
                  stk_d[i] = stk_q[i + 1];
               end
            end
            for (int i = 0; i < DEPTH; i++) begin
               if (4'(i) + 4'd1 == cnt_q) begin
                  stk_d[i] = ps2_byte;
               end
            end
         end
      end else if (is_break && hit) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            if ((4'(i) >= hit_idx) && (4'(i) + 4'd1 < cnt_q)) begin
               stk_d[i] = stk_q[i + 1];
            end
         end
         cnt_d = cnt_q - 4'd1;
      end
   end

   // Next sounding key. The tone keeps its last value while the stack is empty.
   always_comb begin
      top_d = tone_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (4'(i) + 4'd1 == cnt_d) begin
            top_d = stk_d[i];
         end
      end
      tone_d = (cnt_d != 4'd0) ? top_d : tone_q;
   end

`ifdef NOTE_SCHED_RELEASE_EN
   localparam int unsigned RelW = $clog2(RELEASE_CYCLES + 1);

   logic [RelW-1:0] rel_q, rel_d;

   // Release tail: the counter is loaded when the stack empties. The gate drops on the edge
   // where the counter leaves 1. Any make reloads nothing and simply cancels the tail.
   always_comb begin
      rel_d = rel_q;
      aud_d = (cnt_d != 4'd0);
      if (cnt_d != 4'd0) begin
         rel_d = '0;
      end else if (cnt_q != 4'd0) begin
         rel_d = RelW'(RELEASE_CYCLES);
         aud_d = 1'b1;
      end else if (rel_q != '0) begin
         rel_d = rel_q - 1'b1;
         aud_d = (rel_q != RelW'(1));
      end
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         rel_q <= '0;
      end else begin
         rel_q <= rel_d;
      end
   end
`else
   always_comb begin
      aud_d = (cnt_d != 4'd0);
   end
`endif

   // A new change keeps the flag set, even when the datapath accepts the previous update
   // on the same edge.
   always_comb begin
      chg   = (tone_d != tone_q) || (aud_d != aud_q);
      vld_d = chg || (vld_q && !upd_ready);
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         st_q   <= StIdle;
         cnt_q  <= '0;
         tone_q <= '0;
         aud_q  <= 1'b0;
         vld_q  <= 1'b0;
         ovf_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            stk_q[i] <= '0;
         end
      end else begin
         st_q   <= st_d;
         cnt_q  <= cnt_d;
         tone_q <= tone_d;
         aud_q  <= aud_d;
         vld_q  <= vld_d;
         ovf_q  <= ovf_d;
         stk_q  <= stk_d;
      end
   end

   assign upd_valid = vld_q;
   assign tone_hi   = tone_q[7:4];
   assign tone_lo   = tone_q[3:0];
   assign audio_en  = aud_q;
   assign held_cnt  = cnt_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_note_sched.sv
`timescale 1ns / 1ps
// Self-checking bench for ps2_note_sched. A queue-based reference model of the key stack
// predicts each update, and the expected update is pushed to a scoreboard when a byte is driven.
module tb_ps2_note_sched;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned REL   = 8;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [7:0] ps2_byte = 8'h00;
   logic       ps2_valid = 1'b0;
   logic       upd_ready = 1'b0;
   logic       upd_valid;
   logic [3:0] tone_hi, tone_lo, held_cnt;
   logic       audio_en, overflow;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      logic [7:0] tone;
      bit         aud;
   } upd_t;

   logic [7:0] mdl[$];
   upd_t       exp_q[$];
   logic [7:0] m_tone;
   bit         m_aud;
   int         m_st;
   int         m_tail;

   ps2_note_sched #(.DEPTH(DEPTH), .RELEASE_CYCLES(REL)) dut (
      .CLOCK_50 (clk),
      .resetn   (resetn),
      .ps2_byte (ps2_byte),
      .ps2_valid(ps2_valid),
      .upd_ready(upd_ready),
      .upd_valid(upd_valid),
      .tone_hi  (tone_hi),
      .tone_lo  (tone_lo),
      .audio_en (audio_en),
      .held_cnt (held_cnt),
      .overflow (overflow)
   );

   always #10 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic model_reset();
      mdl.delete();
      exp_q.delete();
      m_tone = 8'h00;
      m_aud  = 1'b0;
      m_st   = 0;
      m_tail = 0;
   endtask

   // Reset is applied asynchronously and checked before the next clock edge.
   task automatic do_reset();
      @(negedge clk);
      ps2_valid = 1'b0;
      resetn    = 1'b0;
      model_reset();
      #1;
      chk("rst_tone_hi", 32'(tone_hi), 32'h0);
      chk("rst_tone_lo", 32'(tone_lo), 32'h0);
      chk("rst_audio_en", 32'(audio_en), 32'h0);
      chk("rst_upd_valid", 32'(upd_valid), 32'h0);
      chk("rst_held_cnt", 32'(held_cnt), 32'h0);
      chk("rst_overflow", 32'(overflow), 32'h0);
      @(negedge clk);
      resetn = 1'b1;
   endtask

   // Run one clock cycle, driving a byte when v=1, then check every output against the model.
   task automatic step(input bit v, input logic [7:0] b);
      bit         ovf, make, brk, naud;
      int         pos, prev;
      logic [7:0] ntone;
      upd_t       u;
      ovf  = 1'b0;
      make = 1'b0;
      brk  = 1'b0;
      @(negedge clk);
      ps2_valid = v;
      ps2_byte  = b;
      // A pending update is accepted on this edge when ready is high.
      if (upd_ready) exp_q.delete();
      prev = mdl.size();
      if (v) begin
         case (m_st)
            0: begin
               if (b == 8'hF0) m_st = 1;
               else if (b == 8'hE0) m_st = 2;
               else if (!(b inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF})) make = 1'b1;
            end
            1: begin
               brk  = 1'b1;
               m_st = 0;
            end
            2: m_st = (b == 8'hF0) ? 3 : 0;
            default: m_st = 0;
         endcase
      end
      pos = -1;
      foreach (mdl[i]) if (mdl[i] == b) pos = i;
      if (make) begin
         if (pos < 0) begin
            if (mdl.size() == DEPTH) begin
               void'(mdl.pop_front());
               ovf = 1'b1;
            end
            mdl.push_back(b);
         end else if (pos != mdl.size() - 1) begin
            mdl.delete(pos);
            mdl.push_back(b);
         end
      end else if (brk && pos >= 0) begin
         mdl.delete(pos);
      end
`ifdef NOTE_SCHED_RELEASE_EN
      if (mdl.size() != 0) m_tail = 0;
      else if (prev != 0) m_tail = REL;
      else if (m_tail > 0) m_tail--;
      naud = (mdl.size() != 0) || (m_tail != 0);
`else
      naud = (mdl.size() != 0);
`endif
      ntone = (mdl.size() != 0) ? mdl[$] : m_tone;
      if ((ntone != m_tone) || (naud != m_aud)) begin
         exp_q.delete();
         u.tone = ntone;
         u.aud  = naud;
         exp_q.push_back(u);
      end
      m_tone = ntone;
      m_aud  = naud;
      @(posedge clk);
      #1;
      ps2_valid = 1'b0;
      chk("held_cnt", 32'(held_cnt), 32'(mdl.size()));
      chk("overflow", 32'(overflow), 32'(ovf));
      chk("upd_valid", 32'(upd_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         chk("tone_hi", 32'(tone_hi), 32'(exp_q[0].tone[7:4]));
         chk("tone_lo", 32'(tone_lo), 32'(exp_q[0].tone[3:0]));
         chk("audio_en", 32'(audio_en), 32'(exp_q[0].aud));
      end else begin
         chk("audio_en_idle", 32'(audio_en), 32'(m_aud));
      end
   endtask

   initial begin
      logic [7:0] pool [8];
      pool = '{8'h15, 8'h1D, 8'h1C, 8'h1B, 8'h24, 8'hF0, 8'hE0, 8'hFA};

      do_reset();
      upd_ready = 1'b1;

      // Single key press and release.
      step(1, 8'h1C);
      chk("tp_tone_hi", 32'(tone_hi), 32'h1);
      chk("tp_tone_lo", 32'(tone_lo), 32'hC);
      chk("tp_audio", 32'(audio_en), 32'h1);
      step(1, 8'hF0);
      step(1, 8'h1C);
      chk("tp_brk_cnt", 32'(held_cnt), 32'h0);
      step(0, 8'h00);

      // Fallback to the previous key, and a typematic repeat.
      step(1, 8'h1C);
      step(1, 8'h1B);
      step(1, 8'h1B);
      chk("tp_typematic_vld", 32'(upd_valid), 32'h0);
      step(1, 8'hF0);
      step(1, 8'h1B);
      chk("tp_fallback_lo", 32'(tone_lo), 32'hC);
      step(1, 8'hF0);
      step(1, 8'h1C);

      // Overflow drops the oldest key, so a later break of that key has no effect.
      step(1, 8'h15);
      step(1, 8'h1D);
      step(1, 8'h24);
      step(1, 8'h2D);
      step(1, 8'h2C);
      step(1, 8'hF0);
      step(1, 8'h15);
      chk("tp_ovf_cnt", 32'(held_cnt), 32'h4);
      step(1, 8'h1D);                     // Repress a key that is held but not on top.
      step(1, 8'hF0);
      step(1, 8'h24);                     // Release a key from the middle of the stack.
      for (int i = 0; i < 3; i++) begin
         step(1, 8'hF0);
         step(1, mdl[0]);
      end

      // Extended sequences and ignored bytes.
      step(1, 8'hE0);
      step(1, 8'h75);
      step(1, 8'hE0);
      step(1, 8'hF0);
      step(1, 8'h75);
      step(1, 8'hFA);
      step(1, 8'hAA);
      step(1, 8'h1C);
      chk("tp_ext_idle_lo", 32'(tone_lo), 32'hC);
      step(1, 8'hF0);
      step(1, 8'h1C);
      step(0, 8'h00);

      // Handshake: only the latest pending update is kept while ready is low.
      upd_ready = 1'b0;
      step(1, 8'h1C);
      step(1, 8'h1B);
      step(0, 8'h00);
      chk("tp_hs_lo", 32'(tone_lo), 32'hB);
      upd_ready = 1'b1;
      step(0, 8'h00);
      chk("tp_hs_clear", 32'(upd_valid), 32'h0);
      step(1, 8'hF0);
      step(1, 8'h1B);
      step(1, 8'hF0);
      step(1, 8'h1C);

      // Release tail, including a make during the tail.
      step(1, 8'h1C);
      step(1, 8'hF0);
      step(1, 8'h1C);
      for (int i = 0; i < REL + 2; i++) step(0, 8'h00);
      step(1, 8'h1C);
      step(1, 8'hF0);
      step(1, 8'h1C);
      for (int i = 0; i < 3; i++) step(0, 8'h00);
      step(1, 8'h1B);
      chk("tp_tail_lo", 32'(tone_lo), 32'hB);
      step(1, 8'hF0);
      step(1, 8'h1B);
      for (int i = 0; i < REL + 2; i++) step(0, 8'h00);

      // Random back-to-back bytes with random ready.
      for (int i = 0; i < 80; i++) begin
         upd_ready = 1'($urandom_range(0, 1));
         step(1'($urandom_range(0, 3) != 0), pool[$urandom_range(0, 7)]);
      end
      upd_ready = 1'b1;
      step(0, 8'h00);

      // Reset in the middle of a sequence discards the break prefix.
      step(1, 8'h1B);
      step(1, 8'hF0);
      do_reset();
      step(1, 8'h1B);
      chk("tp_rst_mid_cnt", 32'(held_cnt), 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ps2_note_sched.md
# ps2_note_sched

Sequencing controller between the PS/2 keyboard receiver and the audio tone datapath. Parses the incoming scan-code byte stream (make, break `F0`, extended `E0` prefixes) and keeps a last-pressed-wins stack of held keys. It drives the tone-select nibbles and the audio gate, so released keys stop sounding and chords fall back to the previously held key. Replaces the direct wiring of the raw last received byte into the tone generator.

## Interface

**Parameters**
- `DEPTH`, 4: held-key stack entries (2..8).
- `RELEASE_CYCLES`, 2500000: gate hold-off after the last key is released (50 ms at 50 MHz). Only used with the release feature; must be ≥1.

**Ports**
- `CLOCK_50` input 1: sole clock; all logic is on the rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `ps2_byte` input 8: received scan-code byte.
- `ps2_valid` input 1: one-cycle strobe, `ps2_byte` valid.
- `upd_ready` input 1: tone datapath accepts the update.
- `upd_valid` output 1: new tone/gate pending.
- `tone_hi` output 4: upper nibble of the sounding scan code.
- `tone_lo` output 4: lower nibble of the sounding scan code.
- `audio_en` output 1: audio gate.
- `held_cnt` output 4: number of valid stack entries.
- `overflow` output 1: one-cycle pulse when the oldest entry is dropped.

## Operation

**Parser FSM**
- States are `IDLE`, `BRK`, `EXT` and `EXT_BRK`.
- `IDLE`:
  - `F0` goes to `BRK`.
  - `E0` goes to `EXT`.
  - `00`, `AA`, `FA`, `FE` and `FF` are ignored and the FSM stays in `IDLE`.
  - Any other byte is a make code and the FSM stays in `IDLE`.
- `BRK`: any byte is a break code; the FSM returns to `IDLE`.
- `EXT`:
  - `F0` goes to `EXT_BRK`.
  - Any other byte is consumed without effect and the FSM returns to `IDLE`.
- `EXT_BRK`: any byte is consumed without effect and the FSM returns to `IDLE`. Extended keys never sound.

**Stack behaviour**
- Make, key not present:
  - The key is pushed on top.
  - If the stack is already full (`DEPTH` entries), the bottom (oldest) entry is dropped and `overflow` pulses.
- Make, key present but not on top: the key is moved to the top and the entries above its old slot compact down.
- Make, key already on top (typematic repeat): no change and no update.
- Break, key present: the entry is removed and the entries above it compact down, all in one cycle.
- Break, key absent: no change.

**Outputs and update handshake**
- Sounding key is the top entry. `tone_hi`/`tone_lo` hold the top byte's nibbles. When the stack becomes empty they keep their last value.
- `audio_en` is 1 whenever `held_cnt` is nonzero.
- `upd_valid` is set whenever the top entry or `audio_en` changes.
- `upd_valid` clears on the cycle where `upd_valid` and `upd_ready` are both 1, unless a new change occurs that same cycle, in which case it stays 1. Latest value wins; intermediate values are not queued.

## Timing

- Reset values: `tone_hi`=0, `tone_lo`=0, `audio_en`=0, `upd_valid`=0, `held_cnt`=0, `overflow`=0. Parser is in `IDLE` and the stack is empty. Reset asserted mid-sequence discards any pending prefix or update immediately.
- Latency: when `ps2_valid` is high at edge N, stack, `tone_*`, `held_cnt`, `overflow` and `upd_valid` reflect the byte after edge N (registered, 1 cycle).
- `ps2_valid` may be asserted on consecutive cycles; each byte is processed in one cycle with no backpressure.
- A stack edit and `upd_ready` in the same cycle both take effect.
- `held_cnt` saturates at `DEPTH`; it never wraps.

## Configuration

- `NOTE_SCHED_RELEASE_EN` defined:
  - When `held_cnt` goes 1→0, `audio_en` stays 1 for exactly `RELEASE_CYCLES` further cycles, then drops and sets `upd_valid`.
  - A make during the tail cancels the counter. `audio_en` stays 1 and the new tone is published.
  - The counter is `$clog2(RELEASE_CYCLES+1)` bits and is cleared by reset.
- Not defined: `audio_en` drops on the same edge that empties the stack, and no counter is instantiated.

## Test plan

- **Reset defaults:** reset, then bytes `1C`, `F0 1C` → after `1C`: `tone_hi`=1, `tone_lo`=C, `audio_en`=1, `held_cnt`=1, `upd_valid`=1. After the break: `held_cnt`=0 and, with the macro undefined, `audio_en`=0.
- **Fallback and typematic:** make `1C`, `1B`, `1B`, then break `1B`, with `upd_ready`=1 → tone sequence 1C→1B→1C. The repeated `1B` produces no `upd_valid` pulse. `held_cnt` goes 1,2,2,1.
- **Overflow:** with `DEPTH`=4, makes `15 1D 24 2D 2C` → `overflow` pulses once on `2C`, `held_cnt`=4, and a following break `15` leaves `held_cnt`=4.
- **Extended and ignored bytes:** `E0 75`, `E0 F0 75`, `FA`, `AA` → no stack change, `upd_valid` stays 0, and the parser is back in `IDLE` (a following `1C` sounds).
- **Handshake:** hold `upd_ready`=0 and make `1C` then `1B` → `upd_valid` stays 1 with `tone`=1B. Raising `upd_ready` for one cycle clears it.
- **Release tail:** with the macro defined and `RELEASE_CYCLES`=8, `1C`, `F0 1C` → `audio_en` falls exactly 8 cycles after `held_cnt` reaches 0. Repeating with a make `1B` at cycle 4 keeps `audio_en`=1 with `tone`=1B.
